ddr3_dimm_x16: RTL and testbench

Synthesizable, single-clock, simplified behavioural model of a x16 DDR3 device. It is used as the memory-side counterpart of the system DDR3 controller in top-level simulation. It decodes DDR3 commands and tracks open rows in 8 banks. It stores data in a parameterized internal array and returns BL8 read bursts after the programmed CAS latency. Data moves one beat per rising `ddr_clk` edge (SDR simplification); this is a deliberate model restriction.

---
 rtl/ddr3_dimm_x16.sv | 191 +++++++++++++++++++
 tb/tb_ddr3_dimm_x16.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_dimm_x16.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_dimm_x16
// Purpose  : Single-clock behavioural model of a x16 DDR3 device for
//            controller-level simulation. Decodes DDR3 commands, tracks the
//            open row of each of the 8 banks, stores 16-bit words and plays
//            back fixed BL8 read bursts after the programmed CAS latency.
//            Data moves one beat per rising ddr_clk edge (SDR model).
// Ports    : ddr_clk / rst           - clock, asynchronous active-high reset
//            ddr_clk_n, ddr_odt      - accepted and ignored
//            ddr_cke                 - low: new commands are ignored
//            ddr_cs_n/ras_n/cas_n/we_n, ddr_ba[2:0], ddr_ad[12:0] - command
//            ddr_dm_tdqs[1:0]        - write byte mask (1 = keep old byte)
//            ddr_dq[15:0]            - bidirectional data
//            ddr_dqs[1:0]            - strobe, driven only during reads
//            ddr_dqs_n[1:0]          - never driven
//            err                     - sticky protocol-error flag
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_dimm_x16 #(
    parameter int MEM_ROW_BITS = 2
) (
    input  wire logic        ddr_clk,
    input  wire logic        ddr_clk_n,
    input  wire logic        rst,
    input  wire logic        ddr_cke,
    input  wire logic        ddr_cs_n,
    input  wire logic        ddr_ras_n,
    input  wire logic        ddr_cas_n,
    input  wire logic        ddr_we_n,
    input  wire logic [2:0]  ddr_ba,
    input  wire logic [12:0] ddr_ad,
    input  wire logic        ddr_odt,
    input  wire logic [1:0]  ddr_dm_tdqs,
    inout  wire       [15:0] ddr_dq,
    inout  wire       [1:0]  ddr_dqs,
    inout  wire       [1:0]  ddr_dqs_n,
    output logic             err
);

    localparam int         C_AW      = 3 + MEM_ROW_BITS + 10;
    localparam int         C_DEPTH   = 1 << C_AW;
    localparam logic [3:0] C_CMD_MRS = 4'b0000;
    localparam logic [3:0] C_CMD_REF = 4'b0001;
    localparam logic [3:0] C_CMD_PRE = 4'b0010;
    localparam logic [3:0] C_CMD_ACT = 4'b0011;
    localparam logic [3:0] C_CMD_WR  = 4'b0100;
    localparam logic [3:0] C_CMD_RD  = 4'b0101;

    logic [15:0]             r_mem [0:C_DEPTH-1];
    logic [7:0]              r_open;
    logic [MEM_ROW_BITS-1:0] r_row [0:7];
    logic [3:0]              r_cl;
    logic [3:0]              r_cwl;

    // Burst engine: everything needed to finish a burst is captured at the
    // command edge, so later PRE/MRS commands cannot disturb it.
    logic                    r_busy;
    logic                    r_rd;
    logic                    r_ap;
    logic [2:0]              r_bba;
    logic [C_AW-4:0]         r_base;
    logic [2:0]              r_col_lo;
    logic [3:0]              r_lat;
    logic [4:0]              r_cnt;     // edges elapsed since the command edge

    logic [15:0]             r_dq_out;
    logic                    r_dq_oe;
    logic [1:0]              r_dqs_out;
    logic                    r_dqs_oe;

    logic [3:0]              w_cmd;
    logic [4:0]              w_lat5;
    logic [4:0]              w_rd_off;
    logic [4:0]              w_wr_off;
    logic [2:0]              w_idx;
    logic [C_AW-1:0]         w_addr;
    logic                    w_last;
    logic                    w_rd_pre;
    logic                    w_rd_beat;
    logic                    w_wr_beat;
    logic                    w_unused;

    assign w_cmd    = {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n};
    assign w_lat5   = {1'b0, r_lat};
    // Read beat i is registered at edge L-1+i; write beat i is sampled at L+i.
    assign w_rd_off = r_cnt + 5'd1 - w_lat5;
    assign w_wr_off = r_cnt - w_lat5;
    assign w_idx    = r_rd ? w_rd_off[2:0] : w_wr_off[2:0];
    // Column wraps inside the 8-aligned block.
    assign w_addr   = {r_base, r_col_lo + w_idx};
    assign w_last   = r_busy && (r_cnt == w_lat5 + 5'd7);
    assign w_rd_pre = r_busy && r_rd && (r_cnt + 5'd2 == w_lat5);
    assign w_rd_beat = r_busy && r_rd && (r_cnt + 5'd1 >= w_lat5) && !w_last;
    assign w_wr_beat = r_busy && !r_rd && (r_cnt >= w_lat5);

    assign ddr_dq    = r_dq_oe  ? r_dq_out  : 16'hzzzz;
    assign ddr_dqs   = r_dqs_oe ? r_dqs_out : 2'bzz;
    assign ddr_dqs_n = 2'bzz;

    assign w_unused = &{1'b0, ddr_clk_n, ddr_odt, ddr_ad[12:11], ddr_dqs, ddr_dqs_n};

    always_ff @(posedge ddr_clk or posedge rst) begin
        if (rst) begin
            r_open    <= 8'h00;
            for (int i = 0; i < 8; i++) r_row[i] <= '0;
            r_cl      <= 4'd6;
            r_cwl     <= 4'd5;
            r_busy    <= 1'b0;
            r_rd      <= 1'b0;
            r_ap      <= 1'b0;
            r_bba     <= 3'd0;
            r_base    <= '0;
            r_col_lo  <= 3'd0;
            r_lat     <= 4'd0;
            r_cnt     <= 5'd0;
            r_dq_out  <= 16'h0000;
            r_dq_oe   <= 1'b0;
            r_dqs_out <= 2'b00;
            r_dqs_oe  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (r_busy) r_cnt <= r_cnt + 5'd1;

            if (w_rd_pre) begin
                r_dqs_oe  <= 1'b1;
                r_dqs_out <= 2'b00;
            end
            if (w_rd_beat) begin
                r_dq_oe   <= 1'b1;
                r_dq_out  <= r_mem[w_addr];
                r_dqs_out <= w_idx[0] ? 2'b00 : 2'b11;
            end
            if (w_last) begin
                r_busy   <= 1'b0;
                r_dq_oe  <= 1'b0;
                r_dqs_oe <= 1'b0;
                if (r_ap) r_open[r_bba] <= 1'b0;
            end

            if (ddr_cke) begin
                case (w_cmd)
                    C_CMD_MRS: begin
                        if (ddr_ba[1:0] == 2'd0) r_cl  <= 4'd4 + {1'b0, ddr_ad[6:4]};
                        if (ddr_ba[1:0] == 2'd2) r_cwl <= 4'd5 + {1'b0, ddr_ad[5:3]};
                    end
                    C_CMD_REF: begin
                        if (|r_open) err <= 1'b1;
                    end
                    C_CMD_PRE: begin
                        if (ddr_ad[10]) r_open <= 8'h00;
                        else            r_open[ddr_ba] <= 1'b0;
                    end
                    C_CMD_ACT: begin
                        if (r_open[ddr_ba]) begin
                            err <= 1'b1;
                        end else begin
                            r_open[ddr_ba] <= 1'b1;
                            r_row[ddr_ba]  <= ddr_ad[MEM_ROW_BITS-1:0];
                        end
                    end
                    C_CMD_WR, C_CMD_RD: begin
                        if (!r_open[ddr_ba] || r_busy) begin
                            err <= 1'b1;
                        end else begin
                            r_busy   <= 1'b1;
                            r_rd     <= (w_cmd == C_CMD_RD);
                            r_ap     <= ddr_ad[10];
                            r_bba    <= ddr_ba;
                            r_base   <= {ddr_ba, r_row[ddr_ba], ddr_ad[9:3]};
                            r_col_lo <= ddr_ad[2:0];
                            r_lat    <= (w_cmd == C_CMD_RD) ? r_cl : r_cwl;
                            r_cnt    <= 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage is never reset; the burst engine gate stops writes under reset.
    always_ff @(posedge ddr_clk) begin
        if (w_wr_beat) begin
            if (!ddr_dm_tdqs[0]) r_mem[w_addr][7:0]  <= ddr_dq[7:0];
            if (!ddr_dm_tdqs[1]) r_mem[w_addr][15:8] <= ddr_dq[15:8];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_dimm_x16.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ddr3_dimm_x16
// Purpose  : Self-checking bench for ddr3_dimm_x16. A command table, hand
//            sequences for the multi-cycle corners and a randomized phase are
//            all compared against a word-level reference model of the device.
//            Undriven bus lines are pulled high, so a released bus reads 1s.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_dimm_x16;

    localparam int         MRB   = 2;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_ZQ  = 4'b0110;
    localparam logic [3:0] C_NOP = 4'b0111;

    logic        ddr_clk = 1'b0;
    logic        rst, cke, cs_n, ras_n, cas_n, we_n;
    logic [2:0]  ba;
    logic [12:0] ad;
    logic [1:0]  dm;
    logic        err;
    logic        tb_oe;
    logic [15:0] tb_dq;
    tri1  [15:0] ddr_dq;
    tri1  [1:0]  ddr_dqs;
    tri1  [1:0]  ddr_dqs_n;

    assign ddr_dq = tb_oe ? tb_dq : 16'hzzzz;

    always #5 ddr_clk = ~ddr_clk;

    ddr3_dimm_x16 #(.MEM_ROW_BITS(MRB)) dut (
        .ddr_clk     (ddr_clk),
        .ddr_clk_n   (~ddr_clk),
        .rst         (rst),
        .ddr_cke     (cke),
        .ddr_cs_n    (cs_n),
        .ddr_ras_n   (ras_n),
        .ddr_cas_n   (cas_n),
        .ddr_we_n    (we_n),
        .ddr_ba      (ba),
        .ddr_ad      (ad),
        .ddr_odt     (1'b0),
        .ddr_dm_tdqs (dm),
        .ddr_dq      (ddr_dq),
        .ddr_dqs     (ddr_dqs),
        .ddr_dqs_n   (ddr_dqs_n),
        .err         (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: bank table, latencies, sticky error, byte storage.
    logic       m_open [8];
    int         m_row  [8];
    int         m_cl, m_cwl;
    logic       m_err;
    logic [7:0] m_lo [int];
    logic [7:0] m_hi [int];

    typedef struct {
        logic       cke;
        logic [3:0] cmd;
        logic [2:0] ba;
        logic [12:0] ad;
        logic       exp_err;
    } cmd_vec_t;
    cmd_vec_t vecs [12];

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic int maddr(input int b, input int row, input int col);
        return b * (1 << (MRB + 10)) + (row % (1 << MRB)) * 1024 + col;
    endfunction

    function automatic int beat_col(input int col, input int i);
        return (col & 'h3F8) | ((col + i) & 7);
    endfunction

    task automatic tick();
        @(negedge ddr_clk);
    endtask

    task automatic drive(input logic [3:0] c, input logic [2:0] b, input logic [12:0] a);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b;
        ad = a;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin m_open[i] = 1'b0; m_row[i] = 0; end
        m_cl  = 6;
        m_cwl = 5;
        m_err = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    function automatic void model_cmd(input logic [3:0] c, input logic [2:0] b, input logic [12:0] a);
        case (c)
            C_MRS: begin
                if (b[1:0] == 2'd0) m_cl  = int'(a[6:4]) + 4;
                if (b[1:0] == 2'd2) m_cwl = int'(a[5:3]) + 5;
            end
            C_REF: for (int i = 0; i < 8; i++) if (m_open[i]) m_err = 1'b1;
            C_PRE: begin
                if (a[10]) for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
                else       m_open[b] = 1'b0;
            end
            C_ACT: begin
                if (m_open[b]) m_err = 1'b1;
                else begin m_open[b] = 1'b1; m_row[b] = int'(a); end
            end
            default: ;
        endcase
    endfunction

    task automatic apply_cmd(input logic [3:0] c, input logic [2:0] b, input logic [12:0] a);
        drive(c, b, a);
        tick();
        drive(C_NOP, 3'd0, 13'd0);
        model_cmd(c, b, a);
    endtask

    // Write burst; optionally injects command xc (same bank) at cycle x_at.
    task automatic do_wr(input logic [2:0] b, input logic [9:0] col, input logic ap,
                         input logic [15:0] d [8], input logic [1:0] msk [8],
                         input logic [3:0] xc, input int x_at);
        logic ok;
        int   a;
        ok = m_open[b];
        drive(C_WR, b, {2'b00, ap, col});
        for (int m = 1; m <= m_cwl + 8; m++) begin
            tick();
            drive(C_NOP, 3'd0, 13'd0);
            if (m == x_at) drive(xc, b, {3'b000, col});
            if (m >= m_cwl && m <= m_cwl + 7) begin
                tb_oe = 1'b1; tb_dq = d[m - m_cwl]; dm = msk[m - m_cwl];
            end else begin
                tb_oe = 1'b0; dm = 2'b00;
            end
        end
        if (!ok) m_err = 1'b1;
        else begin
            for (int i = 0; i < 8; i++) begin
                a = maddr(int'(b), m_row[b], beat_col(int'(col), i));
                if (!msk[i][0]) m_lo[a] = d[i][7:0];
                if (!msk[i][1]) m_hi[a] = d[i][15:8];
            end
            if (ap) m_open[b] = 1'b0;
        end
        if (x_at > 0 && xc == C_RD)  m_err = 1'b1;
        if (x_at > 0 && xc == C_PRE) m_open[b] = 1'b0;
        check("wr_err", {15'd0, err}, {15'd0, m_err});
    endtask

    task automatic do_rd(input logic [2:0] b, input logic [9:0] col, input logic ap,
                         input logic [3:0] xc, input int x_at);
        logic        ok;
        logic [15:0] exp [8];
        logic        kn  [8];
        int          a, i;
        ok = m_open[b];
        for (int k = 0; k < 8; k++) begin
            a      = maddr(int'(b), m_row[b], beat_col(int'(col), k));
            kn[k]  = m_lo.exists(a) && m_hi.exists(a);
            exp[k] = kn[k] ? {m_hi[a], m_lo[a]} : 16'h0000;
        end
        drive(C_RD, b, {2'b00, ap, col});
        for (int m = 1; m <= m_cl + 8; m++) begin
            tick();
            drive(C_NOP, 3'd0, 13'd0);
            if (m == x_at) drive(xc, b, {3'b000, col});
            if (!ok || m < m_cl - 1 || m == m_cl + 8) begin
                check("rd_idle_dqs", {14'd0, ddr_dqs}, 16'h0003);
                check("rd_idle_dq", ddr_dq, 16'hFFFF);
            end else if (m == m_cl - 1) begin
                check("rd_preamble_dqs", {14'd0, ddr_dqs}, 16'h0000);
                check("rd_preamble_dq", ddr_dq, 16'hFFFF);
            end else begin
                i = m - m_cl;
                check("rd_beat_dqs", {14'd0, ddr_dqs}, (i % 2 == 0) ? 16'h0003 : 16'h0000);
                if (kn[i]) check($sformatf("rd_beat%0d_dq", i), ddr_dq, exp[i]);
            end
        end
        if (!ok) m_err = 1'b1;
        else if (ap) m_open[b] = 1'b0;
        if (x_at > 0 && xc == C_PRE) m_open[b] = 1'b0;
        if (x_at > 0 && xc == C_RD)  m_err = 1'b1;
        check("rd_err", {15'd0, err}, {15'd0, m_err});
    endtask

    initial begin
        #5_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        logic [15:0] d  [8];
        logic [1:0]  mk [8];
        logic [15:0] rd_d;
        logic [1:0]  rd_m;

        rst = 1'b1; cke = 1'b1; tb_oe = 1'b0; tb_dq = 16'h0000; dm = 2'b00;
        drive(C_NOP, 3'd0, 13'd0);
        for (int i = 0; i < 8; i++) mk[i] = 2'b00;

        // ---- command table: sticky err behaviour -------------------------
        vecs[0]  = '{1'b1, C_PRE, 3'd0, 13'h0400, 1'b0};
        vecs[1]  = '{1'b1, C_REF, 3'd0, 13'h0000, 1'b0};
        vecs[2]  = '{1'b1, C_ACT, 3'd0, 13'h0005, 1'b0};
        vecs[3]  = '{1'b1, C_ACT, 3'd1, 13'h0007, 1'b0};
        vecs[4]  = '{1'b1, C_PRE, 3'd0, 13'h0000, 1'b0};
        vecs[5]  = '{1'b1, C_PRE, 3'd0, 13'h0000, 1'b0};
        vecs[6]  = '{1'b1, C_ZQ,  3'd0, 13'h0000, 1'b0};
        vecs[7]  = '{1'b1, C_MRS, 3'd3, 13'h1FFF, 1'b0};
        vecs[8]  = '{1'b0, C_ACT, 3'd1, 13'h0002, 1'b0};
        vecs[9]  = '{1'b1, 4'b1011, 3'd1, 13'h0002, 1'b0};
        vecs[10] = '{1'b1, C_REF, 3'd0, 13'h0000, 1'b1};
        vecs[11] = '{1'b1, C_ACT, 3'd2, 13'h0001, 1'b1};

        reset_dut();
        check("reset_err", {15'd0, err}, 16'h0000);
        check("reset_dq", ddr_dq, 16'hFFFF);
        check("reset_dqs", {14'd0, ddr_dqs}, 16'h0003);
        check("reset_dqs_n", {14'd0, ddr_dqs_n}, 16'h0003);
        for (int i = 0; i < 12; i++) begin
            cke = vecs[i].cke;
            drive(vecs[i].cmd, vecs[i].ba, vecs[i].ad);
            tick();
            drive(C_NOP, 3'd0, 13'd0);
            cke = 1'b1;
            check($sformatf("tbl%0d_err", i), {15'd0, err}, {15'd0, vecs[i].exp_err});
        end

        // ---- basic write/read, CL = 6 ------------------------------------
        reset_dut();
        apply_cmd(C_MRS, 3'd0, 13'h0020);
        apply_cmd(C_ACT, 3'd3, 13'h0001);
        for (int i = 0; i < 8; i++) d[i] = 16'h1000 + 16'(i);
        do_wr(3'd3, 10'h010, 1'b0, d, mk, C_NOP, 0);
        do_rd(3'd3, 10'h010, 1'b0, C_NOP, 0);

        // ---- wrapping burst -------------------------------------------------
        for (int i = 0; i < 8; i++) d[i] = 16'h2000 + 16'(i);
        do_wr(3'd3, 10'h015, 1'b0, d, mk, C_NOP, 0);
        do_rd(3'd3, 10'h010, 1'b0, C_NOP, 0);
        do_rd(3'd3, 10'h015, 1'b0, C_NOP, 0);

        // ---- byte mask ------------------------------------------------------
        for (int i = 0; i < 8; i++) d[i] = 16'h00AB + 16'(i);
        do_wr(3'd3, 10'h020, 1'b0, d, mk, C_NOP, 0);
        d[0] = 16'hCDEF; mk[0] = 2'b01;
        do_wr(3'd3, 10'h020, 1'b0, d, mk, C_NOP, 0);
        mk[0] = 2'b00;
        do_rd(3'd3, 10'h020, 1'b0, C_NOP, 0);

        // ---- other latencies ------------------------------------------------
        apply_cmd(C_MRS, 3'd2, 13'h0018);   // CWL 8
        apply_cmd(C_MRS, 3'd0, 13'h0050);   // CL 9
        for (int i = 0; i < 8; i++) d[i] = 16'h3A00 + 16'(i * 3);
        do_wr(3'd3, 10'h038, 1'b0, d, mk, C_NOP, 0);
        do_rd(3'd3, 10'h03B, 1'b0, C_NOP, 0);

        // ---- error cases ----------------------------------------------------
        reset_dut();
        do_rd(3'd0, 10'h000, 1'b0, C_NOP, 0);
        repeat (4) tick();
        check("err_sticky_rd_closed", {15'd0, err}, 16'h0001);
        reset_dut();
        check("err_cleared", {15'd0, err}, 16'h0000);
        apply_cmd(C_ACT, 3'd0, 13'h0002);
        apply_cmd(C_ACT, 3'd0, 13'h0003);
        check("err_act_open", {15'd0, err}, 16'h0001);
        reset_dut();
        apply_cmd(C_ACT, 3'd1, 13'h0002);
        apply_cmd(C_REF, 3'd0, 13'h0000);
        check("err_ref_open", {15'd0, err}, 16'h0001);
        reset_dut();
        apply_cmd(C_ACT, 3'd2, 13'h0001);
        for (int i = 0; i < 8; i++) d[i] = 16'h4400 + 16'(i);
        do_wr(3'd2, 10'h000, 1'b0, d, mk, C_RD, 3);
        apply_cmd(C_PRE, 3'd2, 13'h0000);
        check("err_rd_busy_sticky", {15'd0, err}, 16'h0001);

        // ---- PRE mid-read does not abort; then bank is closed --------------
        reset_dut();
        apply_cmd(C_ACT, 3'd3, 13'h0001);
        do_rd(3'd3, 10'h010, 1'b0, C_PRE, 2);
        do_rd(3'd3, 10'h010, 1'b0, C_NOP, 0);

        // ---- auto-precharge read -------------------------------------------
        reset_dut();
        apply_cmd(C_ACT, 3'd3, 13'h0001);
        do_rd(3'd3, 10'h015, 1'b1, C_NOP, 0);
        do_rd(3'd3, 10'h015, 1'b0, C_NOP, 0);

        // ---- reset mid-read --------------------------------------------------
        reset_dut();
        apply_cmd(C_MRS, 3'd0, 13'h0040);   // CL 8
        apply_cmd(C_ACT, 3'd3, 13'h0001);
        drive(C_RD, 3'd3, 13'h0010);
        for (int m = 1; m <= m_cl + 1; m++) begin
            tick();
            drive(C_NOP, 3'd0, 13'd0);
        end
        check("rstmid_beat1_dqs", {14'd0, ddr_dqs}, 16'h0000);
        #2 rst = 1'b1;
        #1;
        check("rstmid_dq_z", ddr_dq, 16'hFFFF);
        check("rstmid_dqs_z", {14'd0, ddr_dqs}, 16'h0003);
        check("rstmid_err", {15'd0, err}, 16'h0000);
        tick();
        rst = 1'b0;
        model_reset();
        do_rd(3'd3, 10'h010, 1'b0, C_NOP, 0);   // banks closed after reset
        reset_dut();
        apply_cmd(C_ACT, 3'd3, 13'h0001);
        do_rd(3'd3, 10'h010, 1'b0, C_NOP, 0);   // CL back to 6

        // ---- randomized phase ------------------------------------------------
        reset_dut();
        for (int it = 0; it < 160; it++) begin
            logic [2:0] oq [$];
            logic [2:0] b;
            logic [9:0] col;
            int         op;
            oq.delete();
            for (int j = 0; j < 8; j++) if (m_open[j]) oq.push_back(3'(j));
            op = $urandom_range(0, 9);
            if (op >= 5 && oq.size() == 0) op = 2;
            b   = (oq.size() > 0) ? oq[$urandom_range(0, oq.size() - 1)] : 3'd0;
            col = 10'($urandom_range(0, 31));
            case (op)
                0, 1: apply_cmd(C_MRS, 3'($urandom), 13'($urandom));
                2, 3: begin
                    b = 3'($urandom);
                    if (m_open[b]) apply_cmd(C_PRE, b, ($urandom_range(0, 3) == 0) ? 13'h0400 : 13'h0000);
                    else           apply_cmd(C_ACT, b, 13'($urandom));
                end
                4: begin
                    if (oq.size() == 0) apply_cmd(C_REF, 3'd0, 13'h0000);
                    else                apply_cmd(C_PRE, b, 13'h0000);
                end
                5, 6, 7: begin
                    for (int i = 0; i < 8; i++) begin
                        rd_d = 16'($urandom);
                        if (rd_d == 16'hFFFF) rd_d = 16'hFFFE;
                        rd_m = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                        d[i] = rd_d; mk[i] = rd_m;
                    end
                    do_wr(b, col, ($urandom_range(0, 5) == 0), d, mk, C_NOP, 0);
                end
                default: do_rd(b, col, ($urandom_range(0, 5) == 0), C_NOP, 0);
            endcase
            check("rnd_err", {15'd0, err}, {15'd0, m_err});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
